// File: rtl/smvm_pkg.sv
// Shared types and trailer field layout for the PL->PS send framer.
// Holds the 32-bit word type, the framer state enum and a trailer builder.
package smvm_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        S_DATA  = 1'b0,
        S_TRAIL = 1'b1
    } state_t;

    localparam int TRL_CNT_LSB    = 0;
    localparam int TRL_CNT_MSB    = 14;
    localparam int TRL_FORCED_BIT = 15;
    localparam int TRL_CKS_LSB    = 16;
    localparam int TRL_CKS_MSB    = 31;

    function automatic word_t make_trailer(
        input logic [14:0] cnt,
        input logic        forced,
        input logic [15:0] cks
    );
        word_t w;
        w = '0;
        w[TRL_CNT_MSB:TRL_CNT_LSB] = cnt;
        w[TRL_FORCED_BIT]          = forced;
        w[TRL_CKS_MSB:TRL_CKS_LSB] = cks;
        return w;
    endfunction

endpackage

// File: rtl/smvm_send_framer_axis_out_reg.sv
// Single-entry AXI4-Stream output register with a load/free handshake.
// Ports: load/load_data/load_last in, tready in, tvalid/tdata/tlast/free out.
module axis_out_reg
    import smvm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  word_t load_data,
    input  logic  load_last,
    input  logic  tready,
    output logic  tvalid,
    output word_t tdata,
    output logic  tlast,
    output logic  free
);

    // Free when empty or being drained this cycle; never looks at load.
    assign free = !tvalid || tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tlast  <= load_last;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/smvm_send_framer.sv
// Send-side framer: packs result words into AXIS frames closed by a trailer
// word {checksum, forced, count}. Ports: in_* valid/ready input, m_axis_*
// stream output, send_fifo_almost_full throttle, frames_sent, busy.
// Optional macro SMVM_SEND_CHECKSUM_EN adds the folded XOR checksum field.
module smvm_send_framer
    import smvm_pkg::*;
#(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        send_fifo_almost_full,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] frames_sent,
    output logic        busy
);

    localparam logic [CNT_W:0] MAX_CNT = (CNT_W+1)'(MAX_WORDS);

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W:0]   cnt_next;
    logic             forced;
    logic             free;
    logic             can_load;
    logic             accept;
    logic             trl_load;
    logic             load;
    logic             last_word;
    logic [15:0]      cks_fold;
    word_t            trailer;
    word_t            load_data;

    assign can_load  = free && !send_fifo_almost_full;
    // Held low during reset so nothing is offered to the producer early.
    assign in_ready  = rst_n && (state == S_DATA) && can_load;
    assign accept    = in_valid && in_ready;
    assign trl_load  = (state == S_TRAIL) && can_load;
    assign load      = accept || trl_load;

    assign cnt_next  = {1'b0, word_cnt} + (CNT_W+1)'(1);
    assign last_word = in_last || (cnt_next == MAX_CNT);

    assign trailer   = make_trailer(15'(word_cnt), forced, cks_fold);
    assign load_data = trl_load ? trailer : in_data;

`ifdef SMVM_SEND_CHECKSUM_EN
    word_t cks;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cks <= '0;
        end else if (trl_load) begin
            cks <= '0;
        end else if (accept) begin
            cks <= cks ^ in_data;
        end
    end

    assign cks_fold = cks[31:16] ^ cks[15:0];
`else
    assign cks_fold = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_DATA;
            word_cnt <= '0;
            forced   <= 1'b0;
        end else begin
            unique case (state)
                S_DATA: begin
                    if (accept) begin
                        word_cnt <= cnt_next[CNT_W-1:0];
                        if (last_word) begin
                            state  <= S_TRAIL;
                            forced <= !in_last;
                        end
                    end
                end
                S_TRAIL: begin
                    if (trl_load) begin
                        state    <= S_DATA;
                        word_cnt <= '0;
                        forced   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Counted at the trailer handshake, not at trailer load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_sent <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frames_sent <= frames_sent + 16'd1;
        end
    end

    axis_out_reg u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_last (trl_load),
        .tready    (m_axis_tready),
        .tvalid    (m_axis_tvalid),
        .tdata     (m_axis_tdata),
        .tlast     (m_axis_tlast),
        .free      (free)
    );

    assign m_axis_tkeep = 4'hF;
    assign busy = (state == S_TRAIL) || (word_cnt != '0) || m_axis_tvalid;

endmodule

// File: tb/tb_smvm_send_framer.sv
// Self-checking bench for smvm_send_framer with a queue-based frame model.
// Directed scenarios followed by randomized traffic; MAX_WORDS set to 4.
module tb_smvm_send_framer;

    localparam int MAXW = 4;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        afull = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        tready = 1'b1;
    logic [15:0] frames_sent;
    logic        busy;

    int          checks = 0;
    int          failures = 0;

    beat_t       q[$];
    int          m_cnt = 0;
    logic [31:0] m_xor = '0;
    int          m_frames = 0;

    logic        acc = 1'b0;
    int          stall_cnt = 0;
    int          beat_cnt = 0;
    bit          chk_alt = 1'b0;
    logic [31:0] last_trl = '0;
    int          f0;

    always #5 clk = ~clk;

    smvm_send_framer #(
        .MAX_WORDS (MAXW),
        .CNT_W     (3)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_data               (in_data),
        .in_last               (in_last),
        .send_fifo_almost_full (afull),
        .m_axis_tdata          (m_axis_tdata),
        .m_axis_tkeep          (m_axis_tkeep),
        .m_axis_tlast          (m_axis_tlast),
        .m_axis_tvalid         (m_axis_tvalid),
        .m_axis_tready         (tready),
        .frames_sent           (frames_sent),
        .busy                  (busy)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] trl(input int n,
                                        input bit f,
                                        input logic [31:0] x);
        logic [15:0] c;
`ifdef SMVM_SEND_CHECKSUM_EN
        c = x[31:16] ^ x[15:0];
`else
        c = 16'h0000;
`endif
        return {c, f, n[14:0]};
    endfunction

    task automatic model_clear();
        q.delete();
        m_cnt = 0;
        m_xor = '0;
        m_frames = 0;
    endtask

    task automatic cycle();
        logic        hs;
        logic        hold;
        logic [31:0] pd;
        logic        pl;
        beat_t       b;
        @(negedge clk);
        acc  = in_valid && in_ready;
        hs   = m_axis_tvalid && tready;
        hold = m_axis_tvalid && !tready;
        pd   = m_axis_tdata;
        pl   = m_axis_tlast;
        if (m_axis_tvalid) check("tkeep", {28'h0, m_axis_tkeep}, 32'hF);
        if (hold || afull)
            check("in_ready_blocked", {31'h0, in_ready}, 32'h0);
        else if (m_cnt != 0 || q.size() == 0)
            check("in_ready_open", {31'h0, in_ready}, 32'h1);
        if (in_valid && !acc) stall_cnt++;
        if (hs) begin
            if (q.size() == 0) begin
                check("unexpected_beat", pd, 32'hDEAD_BEEF);
            end else begin
                b = q.pop_front();
                check("tdata", pd, b.d);
                check("tlast", {31'h0, pl}, {31'h0, b.l});
            end
            if (chk_alt)
                check("tlast_alt", {31'h0, pl}, (beat_cnt % 2));
            beat_cnt++;
            if (pl) begin
                m_frames++;
                last_trl = pd;
            end
        end
        if (acc) begin
            q.push_back('{in_data, 1'b0});
            m_cnt++;
            m_xor ^= in_data;
            if (in_last || m_cnt == MAXW) begin
                q.push_back('{trl(m_cnt, !in_last, m_xor), 1'b1});
                m_cnt = 0;
                m_xor = '0;
            end
        end
        @(posedge clk);
        #1;
        if (hold) begin
            check("hold_tvalid", {31'h0, m_axis_tvalid}, 32'h1);
            check("hold_tdata", m_axis_tdata, pd);
            check("hold_tlast", {31'h0, m_axis_tlast}, {31'h0, pl});
        end
        check("frames_sent", {16'h0, frames_sent},
              {16'h0, m_frames[15:0]});
        check("busy", {31'h0, busy},
              {31'h0, (q.size() != 0) || (m_cnt != 0)});
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            cycle();
            n++;
        end while (!acc && n < 50);
        check("accept_timeout", {31'h0, acc}, 32'h1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        check("rst_tdata", m_axis_tdata, 32'h0);
        check("rst_tlast", {31'h0, m_axis_tlast}, 32'h0);
        check("rst_tkeep", {28'h0, m_axis_tkeep}, 32'hF);
        check("rst_frames", {16'h0, frames_sent}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        #2;
        do_reset();

        // nominal 3-word frame
        send_word(32'h11, 1'b0);
        send_word(32'h22, 1'b0);
        send_word(32'h33, 1'b1);
        idle(3);
        check("nominal_trailer", last_trl, 32'h0000_0003);
        check("nominal_frames", {16'h0, frames_sent}, 32'h1);

        // forced close at MAX_WORDS, then second frame open
        stall_cnt = 0;
        send_word(32'h1, 1'b0);
        send_word(32'h1, 1'b0);
        send_word(32'h2, 1'b0);
        send_word(32'h2, 1'b0);
        send_word(32'h5, 1'b0);
        send_word(32'h6, 1'b0);
        check("forced_stall", stall_cnt, 32'd1);
        idle(2);
        check("forced_trailer", last_trl, 32'h0000_8004);
        check("frame2_open", {31'h0, busy}, 32'h1);
        send_word(32'h7, 1'b1);
        idle(3);

        // backpressure mid-frame
        send_word(32'hCAFE_0001, 1'b0);
        tready = 1'b0;
        in_data = 32'hCAFE_0002;
        in_last = 1'b0;
        repeat (5) cycle();
        tready = 1'b1;
        send_word(32'hCAFE_0002, 1'b0);
        send_word(32'hCAFE_0003, 1'b1);
        idle(3);

        // almost_full with a word and a pending trailer
        tready = 1'b0;
        send_word(32'hA5, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'hB6;
        in_last  = 1'b1;
        afull    = 1'b1;
        cycle();
        tready = 1'b1;
        cycle();
        check("af_drain", {31'h0, m_axis_tvalid}, 32'h0);
        cycle();
        check("af_no_trailer", {31'h0, m_axis_tvalid}, 32'h0);
        afull = 1'b0;
        send_word(32'hB6, 1'b1);
        idle(4);

        // reset mid-frame
        send_word(32'h10, 1'b0);
        send_word(32'h20, 1'b0);
        check("pre_rst_tvalid", {31'h0, m_axis_tvalid}, 32'h1);
        do_reset();
        send_word(32'h77, 1'b1);
        idle(3);
`ifdef SMVM_SEND_CHECKSUM_EN
        check("rst_restart_trl", last_trl, 32'h0077_0001);
`else
        check("rst_restart_trl", last_trl, 32'h0000_0001);
`endif

        // 100 single-word frames at full rate
        f0 = m_frames;
        stall_cnt = 0;
        beat_cnt = 0;
        chk_alt = 1'b1;
        for (int i = 0; i < 100; i++) send_word($urandom, 1'b1);
        check("b2b_stalls", stall_cnt, 32'd99);
        idle(4);
        chk_alt = 1'b0;
        check("b2b_beats", beat_cnt, 32'd200);
        check("b2b_frames", {16'h0, frames_sent},
              {16'h0, 16'(f0 + 100)});

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom % 4) != 0;
                in_data  = $urandom;
                in_last  = ($urandom % 5) == 0;
            end
            tready = ($urandom % 4) != 0;
            afull  = ($urandom % 6) == 0;
            cycle();
        end
        tready = 1'b1;
        afull  = 1'b0;
        in_last = 1'b1;
        if (in_valid && !acc) send_word(in_data, 1'b1);
        idle(4);
        send_word(32'h55, 1'b1);
        idle(8);
        check("drain_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
